axi_lite_reg_slave: RTL

AXI4-Lite responder that terminates an `axi_lite_inf` link driven by a master (BFM or RTL) and exposes a bank of `NREGS` read/write control registers. It sits at the slave end of the lite control path. It accepts independent AW/W channels, returns B and R responses, and flags out-of-range accesses with SLVERR.

---
 rtl/axi_lite_reg_slave.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite responder that terminates a lite control link and exposes a bank
// of NREGS full-word read/write control registers.
//
// Write and read paths are independent. AW and W may arrive in any order;
// each is held until its partner shows up, and the write commits on the edge
// where both are present. Accesses to addresses above the register window
// complete with SLVERR and have no side effects.
//
// Parameters
//   ASIZE : address width
//   DSIZE : data width (32 or 64)
//   NREGS : register count (power of two, 2..256)
//
// Ports
//   axi_lite_aclk / axi_lite_resetn : clock, async active-low reset
//   axi_lite_aw* : write address channel (valid/ready/addr)
//   axi_lite_w*  : write data channel (valid/ready/data, no strobes)
//   axi_lite_b*  : write response channel (valid/ready/resp)
//   axi_lite_ar* : read address channel (valid/ready/addr)
//   axi_lite_r*  : read data channel (valid/ready/data/resp)
//   reg_q        : flattened register contents, reg i at [i*DSIZE +: DSIZE]
//   reg_wr_stb   : one-cycle pulse per register updated
// ---------------------------------------------------------------------------
module axi_lite_reg_slave #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREGS = 16
) (
  input  logic                    axi_lite_aclk,
  input  logic                    axi_lite_resetn,
  input  logic                    axi_lite_awvalid,
  output logic                    axi_lite_awready,
  input  logic [ASIZE-1:0]        axi_lite_awaddr,
  input  logic                    axi_lite_wvalid,
  output logic                    axi_lite_wready,
  input  logic [DSIZE-1:0]        axi_lite_wdata,
  output logic                    axi_lite_bvalid,
  input  logic                    axi_lite_bready,
  output logic [1:0]              axi_lite_bresp,
  input  logic                    axi_lite_arvalid,
  output logic                    axi_lite_arready,
  input  logic [ASIZE-1:0]        axi_lite_araddr,
  output logic                    axi_lite_rvalid,
  input  logic                    axi_lite_rready,
  output logic [DSIZE-1:0]        axi_lite_rdata,
  output logic [1:0]              axi_lite_rresp,
  output logic [NREGS*DSIZE-1:0]  reg_q,
  output logic [NREGS-1:0]        reg_wr_stb
);

  localparam int LSB = $clog2(DSIZE / 8);
  localparam int IW  = $clog2(NREGS);
  localparam int HI  = LSB + IW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // An address is inside the window when every bit above the index is zero.
  function automatic logic addr_ok(input logic [ASIZE-1:0] a);
    return (a >> HI) == {ASIZE{1'b0}};
  endfunction

  // Register index taken from the word address; byte-lane bits are ignored.
  function automatic logic [IW-1:0] addr_idx(input logic [ASIZE-1:0] a);
    return a[LSB +: IW];
  endfunction

  // ---------------- state ----------------
  logic                   aw_hold_q, aw_hold_d;
  logic                   w_hold_q, w_hold_d;
  logic [ASIZE-1:0]       awaddr_q, awaddr_d;
  logic [DSIZE-1:0]       wdata_q, wdata_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [NREGS*DSIZE-1:0] regs_q, regs_d;
  logic [NREGS-1:0]       wr_stb_q, wr_stb_d;
  logic                   rvalid_q, rvalid_d;
  logic [DSIZE-1:0]       rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  // ---------------- handshake decode ----------------
  logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic             aw_present_s, w_present_s;
  logic [ASIZE-1:0] cur_awaddr_s;
  logic [DSIZE-1:0] cur_wdata_s;
  logic             wr_ok_s, rd_ok_s;
  logic [IW-1:0]    wr_idx_s, rd_idx_s;

  // Readies depend only on internal state and reset, never on the *valid inputs.
  assign axi_lite_awready = axi_lite_resetn & ~aw_hold_q & ~bvalid_q;
  assign axi_lite_wready  = axi_lite_resetn & ~w_hold_q  & ~bvalid_q;
  assign axi_lite_arready = axi_lite_resetn & ~rvalid_q;

  assign aw_hs_s = axi_lite_awvalid & axi_lite_awready;
  assign w_hs_s  = axi_lite_wvalid  & axi_lite_wready;
  assign ar_hs_s = axi_lite_arvalid & axi_lite_arready;

  assign aw_present_s = aw_hold_q | aw_hs_s;
  assign w_present_s  = w_hold_q  | w_hs_s;
  assign commit_s     = aw_present_s & w_present_s;

  // A held beat takes precedence over the live bus value.
  assign cur_awaddr_s = aw_hold_q ? awaddr_q : axi_lite_awaddr;
  assign cur_wdata_s  = w_hold_q  ? wdata_q  : axi_lite_wdata;

  assign wr_ok_s  = addr_ok(cur_awaddr_s);
  assign wr_idx_s = addr_idx(cur_awaddr_s);
  assign rd_ok_s  = addr_ok(axi_lite_araddr);
  assign rd_idx_s = addr_idx(axi_lite_araddr);

  // Write path next state: capture AW/W beats, commit when both present, retire B.
  always_comb begin
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    wr_stb_d  = {NREGS{1'b0}};

    if (commit_s) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_ok_s) begin
        regs_d[int'(wr_idx_s)*DSIZE +: DSIZE] = cur_wdata_s;
        wr_stb_d = {{(NREGS-1){1'b0}}, 1'b1} << wr_idx_s;
        bresp_d  = RESP_OKAY;
      end else begin
        wr_stb_d = {NREGS{1'b0}};
        bresp_d  = RESP_SLVERR;
      end
    end else begin
      if (aw_hs_s) begin
        aw_hold_d = 1'b1;
        awaddr_d  = axi_lite_awaddr;
      end else begin
        aw_hold_d = aw_hold_q;
      end
      if (w_hs_s) begin
        w_hold_d = 1'b1;
        wdata_d  = axi_lite_wdata;
      end else begin
        w_hold_d = w_hold_q;
      end
      // bvalid and bresp stay put until the master takes the response.
      if (bvalid_q && axi_lite_bready) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  // Read path next state: register the response on AR handshake, retire on R handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      // Reads sample regs_q, so a same-edge write commit returns the old value.
      if (rd_ok_s) begin
        rdata_d = regs_q[int'(rd_idx_s)*DSIZE +: DSIZE];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = {DSIZE{1'b0}};
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && axi_lite_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Write path state register, including the register bank and strobes.
  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      awaddr_q  <= {ASIZE{1'b0}};
      wdata_q   <= {DSIZE{1'b0}};
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= {(NREGS*DSIZE){1'b0}};
      wr_stb_q  <= {NREGS{1'b0}};
    end else begin
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  // Read path state register.
  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= {DSIZE{1'b0}};
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign axi_lite_bvalid = bvalid_q;
  assign axi_lite_bresp  = bresp_q;
  assign axi_lite_rvalid = rvalid_q;
  assign axi_lite_rdata  = rdata_q;
  assign axi_lite_rresp  = rresp_q;
  assign reg_q           = regs_q;
  assign reg_wr_stb      = wr_stb_q;

endmodule
